alu_execute_stage: RTL and testbench
====================================

Name: alu_execute_stage

Overview:
- Execute stage directly downstream of the ALU decoder; consumes its 3-bit ALU control code with two operands and produces a registered result and zero flag.
- Valid/ready handshake on both sides, so the stage can stall the pipeline.
- Single-cycle ops (add, sub, and, or, xor, slt) complete in 1 cycle.
- Shifts (sll, srl) use an iterative 1-bit-per-cycle shifter unless the fast-shift option is compiled in.
- Feeds writeback and branch resolution.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  drop any in-flight op; has priority over all other inputs except rst.
- in_valid  in  1  upstream presents an op.
- in_ready  out  1  stage accepts the op this cycle.
- alu_control  in  3  op code from the ALU decoder.
- src_a  in  XLEN  operand A.
- src_b  in  XLEN  operand B; for shifts, shift amount is src_b[SHAMT_W-1:0].
- rd_in  in  5  destination register tag.
- reg_write_in  in  1  writeback enable tag.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  XLEN  ALU result.
- zero  out  1  set when result == 0.
- rd_out  out  5  tag passthrough.
- reg_write_out  out  1  tag passthrough.

Behaviour:
- Op encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 slt: signed compare, result 1 or 0, zero-extended.
  - 110 sll, 111 srl (logical, zero fill).
  - Arithmetic is modulo 2^XLEN; no overflow flag.
- FSM states: IDLE, SHIFT, DONE.
- Accept condition: in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - This gives back-to-back throughput of 1 op/cycle for non-shift ops.
- On accept:
  - Latch tags, acc <= src_a, cnt <= shamt.
  - Non-shift op, or shift with shamt==0: compute result, go to DONE. Latency 1 cycle.
  - Shift with shamt>0: go to SHIFT.
- SHIFT state, each cycle:
  - acc shifts 1 bit (left for sll, right for srl); cnt decrements.
  - When cnt==1, transition to DONE.
  - Total latency is 1+shamt cycles from accept to out_valid.
- DONE state:
  - out_valid=1; result, zero and tags are held stable while !out_ready.
  - out_ready && no new accept: go to IDLE.
  - out_ready && accept in the same cycle: load the new op and follow the accept rules above.
- in_ready is 0 throughout SHIFT.
- flush: next state is IDLE and out_valid is 0 the following cycle; any accept in that cycle is discarded.
- rst (also applies mid-operation): state=IDLE, out_valid=0, result=0, zero=1, rd_out=0, reg_write_out=0, acc=0, cnt=0.
- Outputs are registered; no combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.
- Undefined alu_control cannot occur (3-bit code is fully decoded).

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter, the SHIFT state is unused and unreachable, and every op has 1-cycle latency.
- Undefined: iterative shifter as described above; area-minimal.
- Handshake and reset behaviour are identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [2:0] alu_op_e with the eight codes above; the ALU decoder also migrates to it.
  - XLEN default constant.
  - FSM state enum.
- One natural sub-module: alu_core, the pure combinational single-cycle ALU (add/sub/and/or/xor/slt, plus barrel shift when fast-shift is enabled). alu_execute_stage wraps it with the FSM, iterative shifter and handshake.

Test Plan:
- Add back-to-back: add 5+7, then sub 7-7, out_ready=1 → result 12 (zero=0) in cycle T+1, result 0 (zero=1) in T+2; in_ready stays 1.
- slt signed: src_a=0xFFFFFFFF, src_b=1 → result 1. Swapped operands → result 0.
- Iterative sll: src_a=1, shamt=4 → in_ready=0 for 4 cycles, out_valid at T+5, result 0x10. With ALU_FAST_SHIFT_EN: out_valid at T+1.
- Backpressure: srl 0x80000000 by 31, out_ready=0 for 3 cycles → result 1, held stable with out_valid=1 and in_ready=0 until out_ready=1.
- Flush mid-shift: sll by 20, flush at cycle T+5 → out_valid never asserts, state IDLE, in_ready=1 at T+6.
- rst asserted during DONE with out_ready=0 → next cycle out_valid=0, result=0, zero=1, rd_out=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU decoder and execute stage: op codes, default widths, stage FSM states.
package alu_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU. With ALU_FAST_SHIFT_EN it also barrel-shifts;
// otherwise shift ops pass operand A through and the stage shifts iteratively.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  alu_op_e          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  y
);

`ifdef ALU_FAST_SHIFT_EN
  localparam int SHW = $clog2(XLEN);
`endif

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL: y = a << b[SHW-1:0];
      ALU_SRL: y = a >> b[SHW-1:0];
`else
      // a zero shift amount completes here with the operand unchanged
      ALU_SLL, ALU_SRL: y = a;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_execute_stage.sv
// ALU execute stage: valid/ready wrapper around alu_core with an iterative shifter.
// Define ALU_FAST_SHIFT_EN to make shifts single-cycle (SHIFT state then unreachable).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no op held; ready to accept
// ST_SHIFT | shifting acc one bit per cycle, cnt counts down to 1
// ST_DONE  | result valid and held until out_ready; may accept next op
module alu_execute_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_control,
  input  logic [XLEN-1:0]    src_a,
  input  logic [XLEN-1:0]    src_b,
  input  logic [4:0]         rd_in,
  input  logic               reg_write_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               zero,
  output logic [4:0]         rd_out,
  output logic               reg_write_out
);

  state_e              state_q, state_d;
  logic [XLEN-1:0]     acc_q, acc_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                shl_q, shl_d;
  logic                zero_q, zero_d;
  logic [4:0]          rd_q, rd_d;
  logic                rw_q, rw_d;

  alu_op_e             op_in;
  logic [SHAMT_W-1:0]  shamt;
  logic [XLEN-1:0]     core_y;
  logic                accept;

  assign op_in    = alu_op_e'(alu_control);
  assign shamt    = src_b[SHAMT_W-1:0];
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  alu_core #(.XLEN(XLEN)) u_core (
    .op (op_in),
    .a  (src_a),
    .b  (src_b),
    .y  (core_y)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shl_d   = shl_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          acc_d = shl_q ? (acc_q << 1) : (acc_q >> 1);
          cnt_d = cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
        end
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            rd_d  = rd_in;
            rw_d  = reg_write_in;
            cnt_d = shamt;
            shl_d = (op_in == ALU_SLL);
`ifdef ALU_FAST_SHIFT_EN
            acc_d   = core_y;
            state_d = ST_DONE;
`else
            if (is_shift(op_in) && (shamt != '0)) begin
              acc_d   = src_a;
              state_d = ST_SHIFT;
            end else begin
              acc_d   = core_y;
              state_d = ST_DONE;
            end
`endif
          end else if (state_q == ST_DONE && out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    zero_d = (acc_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
      zero_q  <= 1'b1;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
      zero_q  <= zero_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
    end
  end

  assign out_valid     = (state_q == ST_DONE);
  assign result        = acc_q;
  assign zero          = zero_q;
  assign rd_out        = rd_q;
  assign reg_write_out = rw_q;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed self-checking bench for alu_execute_stage; honours ALU_FAST_SHIFT_EN for shift latency.
module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a, src_b, result;
  logic [4:0]  rd_in, rd_out;
  logic        reg_write_in, reg_write_out, zero;

  int vectors = 0;
  int miscompares = 0;

`ifdef ALU_FAST_SHIFT_EN
  localparam int SLL4_WAIT  = 0;
  localparam int SRL31_WAIT = 0;
`else
  localparam int SLL4_WAIT  = 4;
  localparam int SRL31_WAIT = 31;
`endif

  always #5 clk = ~clk;

  alu_execute_stage dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_control   (alu_control),
    .src_a         (src_a),
    .src_b         (src_b),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw);
    in_valid     = 1'b1;
    alu_control  = op;
    src_a        = a;
    src_b        = b;
    rd_in        = rd;
    reg_write_in = rw;
  endtask

  // one isolated single-cycle op: accept, check result next cycle, drain
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    present(op, a, b, 5'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
    tick();
  endtask

  initial begin
    int  n;
    logic ever_valid;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = 3'd0; src_a = '0; src_b = '0; rd_in = '0; reg_write_in = 1'b0;
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_rd_out", {27'd0, rd_out}, 32'd0);
    check("rst_reg_write", {31'd0, reg_write_out}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // back-to-back add then sub
    present(3'b000, 32'd5, 32'd7, 5'd3, 1'b1);
    tick();
    present(3'b001, 32'd7, 32'd7, 5'd4, 1'b0);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", result, 32'd12);
    check("add_zero", {31'd0, zero}, 32'd0);
    check("add_rd", {27'd0, rd_out}, 32'd3);
    check("add_rw", {31'd0, reg_write_out}, 32'd1);
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("sub_valid", {31'd0, out_valid}, 32'd1);
    check("sub_result", result, 32'd0);
    check("sub_zero", {31'd0, zero}, 32'd1);
    check("sub_rd", {27'd0, rd_out}, 32'd4);
    check("sub_rw", {31'd0, reg_write_out}, 32'd0);
    tick();
    check("drain_idle", {31'd0, out_valid}, 32'd0);

    single("slt_neg", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1);
    single("slt_pos", 3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0);
    single("and", 3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    single("or", 3'b011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    single("xor", 3'b100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    single("sub_wrap", 3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF);
    single("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd2, 32'd1);
    single("sll_zero", 3'b110, 32'hA5A5_0001, 32'd0, 32'hA5A5_0001);

    // sll 1 by 4
    present(3'b110, 32'd1, 32'd4, 5'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      check("sll_in_ready_busy", {31'd0, in_ready}, 32'd0);
      tick();
      n++;
    end
    check("sll_latency", n, SLL4_WAIT);
    check("sll_result", result, 32'h0000_0010);
    check("sll_rd", {27'd0, rd_out}, 32'd5);
    tick();

    // srl 0x80000000 by 31 under backpressure
    out_ready = 1'b0;
    present(3'b111, 32'h8000_0000, 32'd31, 5'd6, 1'b1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("srl_latency", n, SRL31_WAIT);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", result, 32'd1);
      check("bp_rd", {27'd0, rd_out}, 32'd6);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // flush mid-shift: sll by 20, flush in T+5
    present(3'b110, 32'd1, 32'd20, 5'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    ever_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ever_valid = ever_valid | out_valid;
      tick();
    end
    ever_valid = ever_valid | out_valid;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      ever_valid = ever_valid | out_valid;
      tick();
    end
`ifndef ALU_FAST_SHIFT_EN
    check("flush_never_valid", {31'd0, ever_valid}, 32'd0);
`endif

    // flush discards a same-cycle accept
    present(3'b000, 32'd1, 32'd1, 5'd8, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_accept_dropped", {31'd0, out_valid}, 32'd0);

    // reset while holding a result in DONE
    out_ready = 1'b0;
    present(3'b000, 32'd3, 32'd4, 5'd10, 1'b1);
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_result", result, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    check("mid_rst_rd", {27'd0, rd_out}, 32'd0);
    check("mid_rst_rw", {31'd0, reg_write_out}, 32'd0);
    out_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
